// File: rtl/pingpong_sample_writer.sv
// pingpong_sample_writer
//   Write side of the FFT input ping-pong buffer. A valid/ready sample stream
//   fills two banks of N/2 samples alternately, bank 0 first. A completed bank
//   is marked in bank_full and stays owned by the reader until rd_release.
//   Holds the 2 x N/2 x DW storage and a registered read port.
//
// Build option
//   PINGPONG_DROP_CNT_EN : in_ready is tied high; samples that arrive while the
//                          current bank is still owned by the reader are
//                          dropped and counted in drop_count (saturating).
//                          Without it the writer back-pressures and
//                          drop_count is driven to 0.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   in_valid     input sample valid
//   in_data      input sample (DW bits)
//   in_ready     writer can accept in_data this cycle (from registers only)
//   wr_bank      bank currently being filled
//   wr_addr      next write slot within wr_bank
//   bank_full    bit b set: bank b complete and owned by the reader
//   rd_bank      bank selected by the reader
//   rd_addr      slot selected by the reader
//   rd_release   one-cycle pulse, reader is done with rd_bank
//   rd_data      mem[rd_bank][rd_addr], one cycle latency
//   drop_count   number of dropped samples (drop build only, else 0)

module pingpong_sample_writer #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic                  wr_bank,
    output logic [$clog2(N)-2:0]  wr_addr,
    output logic [1:0]            bank_full,
    input  logic                  rd_bank,
    input  logic [$clog2(N)-2:0]  rd_addr,
    input  logic                  rd_release,
    output logic [DW-1:0]         rd_data,
    output logic [15:0]           drop_count
);

    localparam int unsigned AW   = $clog2(N) - 1;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned LAST = HALF - 1;

    logic [DW-1:0] mem [2][HALF];

    logic          accept;
    logic          wrap;
    logic          wr_bank_d;
    logic [AW-1:0] wr_addr_d;
    logic [1:0]    bank_full_d;

`ifdef PINGPONG_DROP_CNT_EN
    logic drop;

    // Never back-pressure; a sample hitting a reader-owned bank is discarded.
    assign in_ready = 1'b1;
    assign accept   = in_valid & ~bank_full[wr_bank];
    assign drop     = in_valid &  bank_full[wr_bank];

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 16'd0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    // Back-pressure while the bank being filled is still owned by the reader.
    assign in_ready   = ~bank_full[wr_bank];
    assign accept     = in_valid & in_ready;
    assign drop_count = 16'd0;
`endif

    assign wrap = accept & (wr_addr == AW'(LAST));

    // Next pointer / ownership state. Clear is applied before set so that a
    // set on the same bank wins; a release of a non-full bank changes nothing.
    always_comb begin
        wr_bank_d   = wr_bank;
        wr_addr_d   = wr_addr;
        bank_full_d = bank_full;

        if (rd_release && bank_full[rd_bank]) begin
            bank_full_d[rd_bank] = 1'b0;
        end

        if (accept) begin
            // HALF is a power of two, so the natural wrap of AW bits is modulo N/2.
            wr_addr_d = wr_addr + AW'(1);
            if (wrap) begin
                bank_full_d[wr_bank] = 1'b1;
                wr_bank_d            = ~wr_bank;
            end
        end
    end

    // Pointer / ownership registers and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            bank_full <= 2'b00;
            rd_data   <= '0;
        end else begin
            wr_bank   <= wr_bank_d;
            wr_addr   <= wr_addr_d;
            bank_full <= bank_full_d;
            rd_data   <= mem[rd_bank][rd_addr];
        end
    end

    // Sample storage, not reset. A same-cycle read of this slot sees old data.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_addr] <= in_data;
        end
    end

endmodule
